// File: rtl/prio_req_capture_pkg.sv
// Shared constants for the request-capture stage and the 4-input priority encoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package prio_req_capture_pkg;

  // Encoder output codes; the capture stage decodes the same codes on ack.
  localparam logic [2:0] CODE_NONE = 3'b000;
  localparam logic [2:0] CODE_R1   = 3'b001;
  localparam logic [2:0] CODE_R2   = 3'b010;
  localparam logic [2:0] CODE_R3   = 3'b011;
  localparam logic [2:0] CODE_R4   = 3'b100;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int N_REQ           = 4;

  // One-hot clear vector for a serviced code; unused codes clear nothing.
  function automatic logic [4:1] ack_onehot(input logic vld, input logic [2:0] code);
    logic [4:1] oh;
    oh = 4'b0000;
    if (vld) begin
      case (code)
        CODE_R1: oh = 4'b0001;
        CODE_R2: oh = 4'b0010;
        CODE_R3: oh = 4'b0100;
        CODE_R4: oh = 4'b1000;
        default: oh = 4'b0000;
      endcase
    end
    return oh;
  endfunction

endpackage

// File: rtl/prio_req_capture_sync.sv
// Synchroniser chain plus history flop for one async request line; flags 0->1 edges.
// Latency: rise asserts SYNC_STAGES edges after the line goes high, for one cycle.
// Backpressure: none; an edge is reported once regardless of the consumer.
module req_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic req_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   hist_q;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], req_i};

  // Shift the raw level through the chain; history remembers the last synced level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // History clears on reset, so a level held through reset still produces one edge.
  assign rise_o = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/prio_req_capture.sv
// Captures rising edges of four async requests into sticky pending bits for the priority encoder.
// Latency: pend sets SYNC_STAGES+1 edges after req_in rises; r/pend_cnt are combinational from pend.
// Backpressure: none; a repeat event on a pending bit raises overrun instead of queueing.
module prio_req_capture
  import prio_req_capture_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int N           = N_REQ
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N:1]   req_in,
  input  logic [N:1]   mask,
  input  logic         ack,
  input  logic [2:0]   ack_code,
  input  logic         ovr_clr,
  output logic [N:1]   r,
  output logic [N:1]   pend,
  output logic [N:1]   overrun,
  output logic [2:0]   pend_cnt
);

  logic [N:1] rise;
  logic [N:1] clr;
  logic [N:1] pend_q, pend_d;
  logic [N:1] ovr_q, ovr_d;
  logic [N:1] ovr_set;

  for (genvar i = 1; i <= N; i++) begin : g_sync
    req_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .req_i   (req_in[i]),
      .rise_o  (rise[i])
    );
  end

  assign clr = ack_onehot(ack, ack_code);

  // A new event beats a same-cycle ack so it is never lost; an ack-covered repeat is not an overrun.
  always_comb begin
    pend_d  = rise | (pend_q & ~clr);
    ovr_set = rise & pend_q & ~clr;
    ovr_d   = ovr_set | (ovr_clr ? '0 : ovr_q);
  end

  // Pending and overrun state; async reset discards everything immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q <= '0;
      ovr_q  <= '0;
    end else begin
      pend_q <= pend_d;
      ovr_q  <= ovr_d;
    end
  end

  // Population count of raw pending bits, masked or not.
  always_comb begin
    pend_cnt = 3'd0;
    for (int i = 1; i <= N; i++) begin
      pend_cnt = pend_cnt + {2'b00, pend_q[i]};
    end
  end

  assign pend    = pend_q;
  assign overrun = ovr_q;
  assign r       = pend_q & mask;

endmodule

// File: tb/tb_prio_req_capture.sv
// Directed bench for prio_req_capture: per-cycle vector table plus hand sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_prio_req_capture;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [4:1] req_in;
  logic [4:1] mask;
  logic       ack;
  logic [2:0] ack_code;
  logic       ovr_clr;
  logic [4:1] r;
  logic [4:1] pend;
  logic [4:1] overrun;
  logic [2:0] pend_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  prio_req_capture dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req_in   (req_in),
    .mask     (mask),
    .ack      (ack),
    .ack_code (ack_code),
    .ovr_clr  (ovr_clr),
    .r        (r),
    .pend     (pend),
    .overrun  (overrun),
    .pend_cnt (pend_cnt)
  );

  typedef struct {
    logic [3:0] req;
    logic [3:0] msk;
    logic       ak;
    logic [2:0] code;
    logic       oclr;
    logic [3:0] e_pend;
    logic [3:0] e_ovr;
  } vec_t;

  vec_t vq1[$];
  vec_t vq2[$];

  function automatic vec_t mk(input logic [3:0] rq, input logic [3:0] m, input logic a,
                              input logic [2:0] c, input logic oc,
                              input logic [3:0] ep, input logic [3:0] eo);
    vec_t v;
    v.req = rq; v.msk = m; v.ak = a; v.code = c; v.oclr = oc;
    v.e_pend = ep; v.e_ovr = eo;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one vector, let one edge pass, then check pend/r/overrun/pend_cnt.
  task automatic run_vec(input vec_t v, input int idx);
    logic [3:0] er;
    logic [2:0] ec;
    string tag;
    req_in = v.req; mask = v.msk; ack = v.ak; ack_code = v.code; ovr_clr = v.oclr;
    @(posedge clk);
    #1;
    er  = v.e_pend & v.msk;
    ec  = 3'($countones(v.e_pend));
    tag = $sformatf("step%0d", idx);
    chk({tag, ".pend"},     32'(pend),     32'(v.e_pend));
    chk({tag, ".r"},        32'(r),        32'(er));
    chk({tag, ".overrun"},  32'(overrun),  32'(v.e_ovr));
    chk({tag, ".pend_cnt"}, 32'(pend_cnt), 32'(ec));
    @(negedge clk);
  endtask

  initial begin
    // Reset release, acks of bits 2/4, single event on bit 3.
    vq1.push_back(mk(4'b1010, 4'b1111, 0, 3'd0, 0, 4'b0000, 4'b0000)); // 1
    vq1.push_back(mk(4'b1010, 4'b1111, 0, 3'd0, 0, 4'b0000, 4'b0000)); // 2
    vq1.push_back(mk(4'b1010, 4'b1111, 0, 3'd0, 0, 4'b1010, 4'b0000)); // 3
    vq1.push_back(mk(4'b1010, 4'b1111, 1, 3'd2, 0, 4'b1000, 4'b0000)); // 4
    vq1.push_back(mk(4'b1010, 4'b1111, 1, 3'd4, 0, 4'b0000, 4'b0000)); // 5
    vq1.push_back(mk(4'b1110, 4'b1111, 0, 3'd0, 0, 4'b0000, 4'b0000)); // 6
    vq1.push_back(mk(4'b1110, 4'b1111, 0, 3'd0, 0, 4'b0000, 4'b0000)); // 7
    vq1.push_back(mk(4'b1110, 4'b1111, 0, 3'd0, 0, 4'b0100, 4'b0000)); // 8
    vq1.push_back(mk(4'b1110, 4'b1111, 1, 3'd3, 0, 4'b0000, 4'b0000)); // 9
    // Bit 2: fresh event, then a second event while pending -> overrun, then clear.
    vq1.push_back(mk(4'b1100, 4'b1111, 0, 3'd0, 0, 4'b0000, 4'b0000)); // 10
    vq1.push_back(mk(4'b1100, 4'b1111, 0, 3'd0, 0, 4'b0000, 4'b0000)); // 11
    vq1.push_back(mk(4'b1110, 4'b1111, 0, 3'd0, 0, 4'b0000, 4'b0000)); // 12
    vq1.push_back(mk(4'b1110, 4'b1111, 0, 3'd0, 0, 4'b0000, 4'b0000)); // 13
    vq1.push_back(mk(4'b1110, 4'b1111, 0, 3'd0, 0, 4'b0010, 4'b0000)); // 14
    vq1.push_back(mk(4'b1100, 4'b1111, 0, 3'd0, 0, 4'b0010, 4'b0000)); // 15
    vq1.push_back(mk(4'b1100, 4'b1111, 0, 3'd0, 0, 4'b0010, 4'b0000)); // 16
    vq1.push_back(mk(4'b1110, 4'b1111, 0, 3'd0, 0, 4'b0010, 4'b0000)); // 17
    vq1.push_back(mk(4'b1110, 4'b1111, 0, 3'd0, 0, 4'b0010, 4'b0000)); // 18
    vq1.push_back(mk(4'b1110, 4'b1111, 0, 3'd0, 0, 4'b0010, 4'b0010)); // 19
    vq1.push_back(mk(4'b1110, 4'b1111, 0, 3'd0, 1, 4'b0010, 4'b0000)); // 20
    // Bit 1: set, then a repeat event racing an ack of the same bit.
    vq1.push_back(mk(4'b1111, 4'b1111, 0, 3'd0, 0, 4'b0010, 4'b0000)); // 21
    vq1.push_back(mk(4'b1111, 4'b1111, 0, 3'd0, 0, 4'b0010, 4'b0000)); // 22
    vq1.push_back(mk(4'b1111, 4'b1111, 0, 3'd0, 0, 4'b0011, 4'b0000)); // 23
    vq1.push_back(mk(4'b1110, 4'b1111, 0, 3'd0, 0, 4'b0011, 4'b0000)); // 24
    vq1.push_back(mk(4'b1110, 4'b1111, 0, 3'd0, 0, 4'b0011, 4'b0000)); // 25
    vq1.push_back(mk(4'b1111, 4'b1111, 0, 3'd0, 0, 4'b0011, 4'b0000)); // 26
    vq1.push_back(mk(4'b1111, 4'b1111, 0, 3'd0, 0, 4'b0011, 4'b0000)); // 27
    vq1.push_back(mk(4'b1111, 4'b1111, 1, 3'd1, 0, 4'b0011, 4'b0000)); // 28
    // Fill all four, then mask and invalid ack codes.
    vq1.push_back(mk(4'b0011, 4'b1111, 0, 3'd0, 0, 4'b0011, 4'b0000)); // 29
    vq1.push_back(mk(4'b0011, 4'b1111, 0, 3'd0, 0, 4'b0011, 4'b0000)); // 30
    vq1.push_back(mk(4'b1111, 4'b1111, 0, 3'd0, 0, 4'b0011, 4'b0000)); // 31
    vq1.push_back(mk(4'b1111, 4'b1111, 0, 3'd0, 0, 4'b0011, 4'b0000)); // 32
    vq1.push_back(mk(4'b1111, 4'b1111, 0, 3'd0, 0, 4'b1111, 4'b0000)); // 33
    vq1.push_back(mk(4'b1111, 4'b0101, 0, 3'd0, 0, 4'b1111, 4'b0000)); // 34
    vq1.push_back(mk(4'b1111, 4'b0101, 1, 3'd0, 0, 4'b1111, 4'b0000)); // 35
    vq1.push_back(mk(4'b1111, 4'b0101, 1, 3'd7, 0, 4'b1111, 4'b0000)); // 36
    vq1.push_back(mk(4'b1111, 4'b0101, 1, 3'd5, 0, 4'b1111, 4'b0000)); // 37
    // Reach pend=0110, overrun=0010 ahead of the async reset pulse.
    vq2.push_back(mk(4'b1111, 4'b1111, 1, 3'd1, 0, 4'b1110, 4'b0000)); // 38
    vq2.push_back(mk(4'b1111, 4'b1111, 1, 3'd4, 0, 4'b0110, 4'b0000)); // 39
    vq2.push_back(mk(4'b1101, 4'b1111, 0, 3'd0, 0, 4'b0110, 4'b0000)); // 40
    vq2.push_back(mk(4'b1101, 4'b1111, 0, 3'd0, 0, 4'b0110, 4'b0000)); // 41
    vq2.push_back(mk(4'b1111, 4'b1111, 0, 3'd0, 0, 4'b0110, 4'b0000)); // 42
    vq2.push_back(mk(4'b1111, 4'b1111, 0, 3'd0, 0, 4'b0110, 4'b0000)); // 43
    vq2.push_back(mk(4'b1111, 4'b1111, 0, 3'd0, 0, 4'b0110, 4'b0010)); // 44

    // Hold reset with lines high; nothing may capture.
    reset_n = 1'b0; req_in = 4'b1010; mask = 4'b1111;
    ack = 1'b0; ack_code = 3'd0; ovr_clr = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("rst.r",        32'(r),        32'h0);
    chk("rst.pend",     32'(pend),     32'h0);
    chk("rst.overrun",  32'(overrun),  32'h0);
    chk("rst.pend_cnt", 32'(pend_cnt), 32'h0);

    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < vq1.size(); i++) run_vec(vq1[i], i + 1);

    // Unmasking shows pending bits on r without a clock edge.
    mask = 4'b1111;
    #1;
    chk("unmask.r",    32'(r),    32'hF);
    chk("unmask.pend", 32'(pend), 32'hF);
    mask = 4'b0000;
    #1;
    chk("maskall.r",   32'(r),    32'h0);
    @(negedge clk);

    for (int i = 0; i < vq2.size(); i++) run_vec(vq2[i], i + 38);

    // Async reset between edges clears everything immediately.
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst.r",        32'(r),        32'h0);
    chk("arst.pend",     32'(pend),     32'h0);
    chk("arst.overrun",  32'(overrun),  32'h0);
    chk("arst.pend_cnt", 32'(pend_cnt), 32'h0);
    @(posedge clk);
    #1;
    chk("arst_hold.pend", 32'(pend), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
